// File: rtl/mbist_march_ctrl_pkg.sv
// mbist_pkg: shared definitions for the March C- MBIST sequencer.
//   - controller state encoding
//   - March C- element table (op count, direction, per-op read/write and data value)
//   - helper to look up one op of one element
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int NUM_ELEM = 6;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Element table, one bit per element (bit e = element e). Only bits 0-5
    // are meaningful; the vectors are 8 wide so a 3-bit index never runs off
    // the end.
    //   E0: w0 up | E1: r0 w1 up | E2: r1 w0 up
    //   E3: r0 w1 dn | E4: r1 w0 dn | E5: r0 dn
    localparam logic [7:0] ELEM_DIR     = 8'b0011_1000;  // 1 = down
    localparam logic [7:0] ELEM_LAST_OP = 8'b0001_1110;  // index of last op (0 or 1)
    localparam logic [7:0] OP0_WR       = 8'b0000_0001;
    localparam logic [7:0] OP0_VAL      = 8'b0001_0100;
    localparam logic [7:0] OP1_WR       = 8'b0001_1110;
    localparam logic [7:0] OP1_VAL      = 8'b0000_1010;

    typedef struct packed {
        logic wr;   // 1 = write, 0 = read
        logic val;  // background bit: written value, or expected read value
    } march_op_t;

    function automatic march_op_t elem_op(input logic [2:0] elem, input logic op);
        march_op_t r;
        r.wr  = op ? OP1_WR[elem]  : OP0_WR[elem];
        r.val = op ? OP1_VAL[elem] : OP0_VAL[elem];
        return r;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_resp_cmp.sv
// mbist_resp_cmp: read-response checker for the March C- sequencer.
// A read issued in cycle t is registered here (expected background, address,
// element); in cycle t+1 the memory's synchronous read data is compared. The
// first mismatch sets a sticky fail flag and captures address/element; later
// mismatches leave the capture alone until the next clear.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_clr           clear fail flag and capture (start of a new test)
//   i_rd            a read is issued this cycle
//   i_exp           expected read data for that read
//   i_addr, i_elem  address / element index of that read
//   i_rdata         memory read data (valid the cycle after the read)
//   o_fail          sticky mismatch flag
//   o_fail_addr     address of first mismatch
//   o_fail_elem     element index of first mismatch
module mbist_resp_cmp #(
    parameter int ADDR = 8,
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_rd,
    input  logic [DATA-1:0] i_exp,
    input  logic [ADDR-1:0] i_addr,
    input  logic [2:0]      i_elem,
    input  logic [DATA-1:0] i_rdata,
    output logic            o_fail,
    output logic [ADDR-1:0] o_fail_addr,
    output logic [2:0]      o_fail_elem
);

    logic            r_cmp_vld;
    logic [DATA-1:0] r_exp;
    logic [ADDR-1:0] r_cmp_addr;
    logic [2:0]      r_cmp_elem;
    logic            r_fail;
    logic [ADDR-1:0] r_fail_addr;
    logic [2:0]      r_fail_elem;
    logic            w_mis;

    assign w_mis = r_cmp_vld && (i_rdata != r_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_vld   <= 1'b0;
            r_exp       <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
        end else begin
            r_cmp_vld  <= i_rd;
            r_exp      <= i_exp;
            r_cmp_addr <= i_addr;
            r_cmp_elem <= i_elem;
            if (i_clr) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= '0;
            end else if (w_mis) begin
                r_fail <= 1'b1;
                // Only the first failure is kept.
                if (!r_fail) begin
                    r_fail_addr <= r_cmp_addr;
                    r_fail_elem <= r_cmp_elem;
                end
            end
        end
    end

    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_elem = r_fail_elem;

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- sequencer for one single-port SRAM.
// Steps an external address generator through the six March C- elements,
// issuing one memory op per cycle, and checks read data one cycle later.
// Ports:
//   clk, rst_n              clock, async active-low reset (shared with generator)
//   start                   start pulse, honoured only when idle or done
//   addr_i, addr_done_i     generator address and "last address" flag
//   addr_en_o, addr_ff_o    generator control: [1] advance, [0] dir; ff = hold (up)
//   mem_cs/we/addr/wdata    memory test-mode command port
//   mem_rdata               memory read data, one cycle after a read
//   busy, done              status (done held until next start)
//   fail, fail_addr/elem    sticky fail flag and first-failure capture
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR = 8,
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR-1:0] addr_i,
    input  logic            addr_done_i,
    output logic [1:0]      addr_en_o,
    output logic            addr_ff_o,
    output logic            mem_cs,
    output logic            mem_we,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_wdata,
    input  logic [DATA-1:0] mem_rdata,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [ADDR-1:0] fail_addr,
    output logic [2:0]      fail_elem
);

    state_t          r_state, w_state_nx;
    logic [2:0]      r_elem, w_elem_nx;
    logic            r_op, w_op_nx;

    march_op_t       w_op;
    logic            w_last_op;
    logic            w_clr;
    logic            w_rd;
    logic [DATA-1:0] w_exp;

    assign w_op      = elem_op(r_elem, r_op);
    assign w_last_op = (r_op == ELEM_LAST_OP[r_elem]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_elem  <= '0;
            r_op    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_elem  <= w_elem_nx;
            r_op    <= w_op_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_elem_nx  = r_elem;
        w_op_nx    = r_op;
        addr_en_o  = 2'b00;
        addr_ff_o  = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        w_clr      = 1'b0;
        w_rd       = 1'b0;
        w_exp      = '0;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clr      = 1'b1;
                    w_elem_nx  = '0;
                    w_op_nx    = 1'b0;
                    w_state_nx = ST_RUN;
                end
            end

            ST_RUN: begin
                mem_cs    = 1'b1;
                mem_we    = w_op.wr;
                mem_wdata = w_op.wr ? {DATA{w_op.val}} : '0;
                w_rd      = !w_op.wr;
                w_exp     = {DATA{w_op.val}};
                // Advance only after the last op at this address.
                addr_en_o = {w_last_op, ELEM_DIR[r_elem]};
                if (w_last_op) begin
                    w_op_nx = 1'b0;
                    if (addr_done_i) begin
                        // E2 ends at MAX going up; holding there makes the
                        // generator hand E3 its starting address (MAX, down).
                        if (r_elem == 3'd2)
                            addr_ff_o = 1'b1;
                        if (r_elem == 3'(NUM_ELEM - 1))
                            w_state_nx = ST_FIN;
                        else
                            w_elem_nx = r_elem + 3'd1;
                    end
                end else begin
                    w_op_nx = 1'b1;
                end
            end

            ST_FIN: begin
                // E5 left the generator at MAX; one up-step wraps it to 0 so
                // the next run starts cleanly. Last compare resolves here.
                addr_en_o  = 2'b10;
                w_state_nx = ST_DONE;
            end

            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign mem_addr = addr_i;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_FIN);
    assign done     = (r_state == ST_DONE);

    mbist_resp_cmp #(
        .ADDR (ADDR),
        .DATA (DATA)
    ) u_resp_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_rd        (w_rd),
        .i_exp       (w_exp),
        .i_addr      (addr_i),
        .i_elem      (r_elem),
        .i_rdata     (mem_rdata),
        .o_fail      (fail),
        .o_fail_addr (fail_addr),
        .o_fail_elem (fail_elem)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl (ADDR=4, DATA=8): models the address generator
// and a synchronous-read SRAM with stuck-at fault masks, and checks each run
// against an abstract March C- walk over an array.
module tb_mbist_march_ctrl;

    localparam int ADDR = 4;
    localparam int DATA = 8;
    localparam int N    = 1 << ADDR;
    localparam int RUN_CYC = 10 * N + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [ADDR-1:0] addr_i;
    logic            addr_done_i;
    logic [1:0]      addr_en_o;
    logic            addr_ff_o;
    logic            mem_cs, mem_we;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_wdata;
    logic [DATA-1:0] mem_rdata = '0;
    logic            busy, done, fail;
    logic [ADDR-1:0] fail_addr;
    logic [2:0]      fail_elem;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR(ADDR), .DATA(DATA)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .addr_i      (addr_i),
        .addr_done_i (addr_done_i),
        .addr_en_o   (addr_en_o),
        .addr_ff_o   (addr_ff_o),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .fail_addr   (fail_addr),
        .fail_elem   (fail_elem)
    );

    // Address generator: wraps in both directions, ff holds in up mode.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_i <= '0;
        else if (addr_en_o[1] && !(addr_ff_o && !addr_en_o[0]))
            addr_i <= addr_en_o[0] ? addr_i - 1'b1 : addr_i + 1'b1;
    end
    assign addr_done_i = addr_en_o[0] ? (addr_i == '0) : (addr_i == ADDR'(N - 1));

    // SRAM with stuck-at masks applied on read.
    logic [DATA-1:0] mem [N];
    logic [DATA-1:0] sa1 [N];
    logic [DATA-1:0] sa0 [N];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= (mem[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
        end
    end

    // Access / handshake monitor.
    typedef struct packed {
        logic [ADDR-1:0] a;
        logic            we;
        logic [DATA-1:0] wd;
    } acc_t;
    acc_t obs_q[$];
    int   ff_q[$];
    always @(negedge clk) begin
        if (addr_ff_o) ff_q.push_back(obs_q.size());
        if (mem_cs) obs_q.push_back('{mem_addr, mem_we, mem_wdata});
    end

    // March C- as a table: op code bit1 = write, bit0 = data value.
    // r0=0 r1=1 w0=2 w1=3
    int E_NOPS [6]    = '{1, 2, 2, 2, 2, 1};
    int E_DOWN [6]    = '{0, 0, 0, 1, 1, 1};
    int E_OPS  [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};

    acc_t exp_q[$];
    int   exp_ff_idx;
    logic exp_fail;
    int   exp_faddr, exp_felem;

    task automatic ref_model();
        logic [DATA-1:0] m [N];
        exp_q.delete();
        exp_ff_idx = -1;
        exp_fail   = 1'b0;
        exp_faddr  = 0;
        exp_felem  = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                a = (E_DOWN[e] != 0) ? N - 1 - k : k;
                for (int o = 0; o < E_NOPS[e]; o++) begin
                    int code;
                    logic v, wr;
                    logic [DATA-1:0] rd;
                    code = E_OPS[e][o];
                    v    = code[0];
                    wr   = code[1];
                    if (e == 2 && k == N - 1 && o == E_NOPS[e] - 1)
                        exp_ff_idx = exp_q.size();
                    exp_q.push_back('{ADDR'(a), wr, wr ? {DATA{v}} : {DATA{1'b0}}});
                    if (wr) begin
                        m[a] = {DATA{v}};
                    end else begin
                        rd = (m[a] | sa1[a]) & ~sa0[a];
                        if (rd != {DATA{v}} && !exp_fail) begin
                            exp_fail  = 1'b1;
                            exp_faddr = a;
                            exp_felem = e;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, 32'({addr_en_o, addr_ff_o, mem_cs, mem_we, mem_addr, mem_wdata,
                      busy, done, fail, fail_addr, fail_elem}), 32'd0);
    endtask

    // One full run; optional start pulse at cycle pulse_at (-1 = none).
    task automatic run_test(input string nm, input int pulse_at);
        int cyc;
        int n;
        ref_model();
        @(posedge clk); #1;
        obs_q.delete();
        ff_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, ":busy_at_start"}, 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            start = (cyc == pulse_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({nm, ":duration"}, 32'(cyc), 32'(RUN_CYC));
        chk({nm, ":done"}, 32'(done), 32'd1);
        chk({nm, ":busy_end"}, 32'(busy), 32'd0);
        chk({nm, ":fail"}, 32'(fail), 32'(exp_fail));
        chk({nm, ":fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
        chk({nm, ":fail_elem"}, 32'(fail_elem), 32'(exp_felem));
        chk({nm, ":n_access"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s:acc%0d", nm, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({nm, ":n_ff"}, 32'(ff_q.size()), 32'd1);
        if (ff_q.size() > 0)
            chk({nm, ":ff_idx"}, 32'(ff_q[0]), 32'(exp_ff_idx));
        chk({nm, ":addr_after"}, 32'(mem_addr), 32'd0);
        // Done is a level; it must hold with no new start.
        repeat (3) @(posedge clk);
        #1;
        chk({nm, ":done_hold"}, 32'(done), 32'd1);
    endtask

    initial begin
        int ra, rb;
        clear_faults();
        #1;
        outs_zero("reset_outs");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        outs_zero("idle_outs");

        run_test("clean1", -1);
        run_test("clean2", -1);

        sa1[5] = 8'h01;
        run_test("sa1_a5_b0", -1);
        clear_faults();

        sa0[10] = 8'hFF;
        run_test("sa0_aA", -1);
        clear_faults();

        run_test("start_mid", 50);

        for (int t = 0; t < 3; t++) begin
            ra = $urandom_range(N - 1, 0);
            rb = $urandom_range(DATA - 1, 0);
            if ($urandom_range(1, 0) == 1) sa1[ra][rb] = 1'b1;
            else                           sa0[ra][rb] = 1'b1;
            run_test($sformatf("rand%0d", t), -1);
            clear_faults();
        end

        // Reset mid-test with a fault already recorded.
        sa1[5] = 8'h01;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_fail", 32'(fail), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        outs_zero("mid_rst_outs");
        @(posedge clk); #1;
        outs_zero("mid_rst_hold");
        rst_n = 1'b1;
        clear_faults();
        run_test("post_rst", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
